// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time on the instruction bus and hands {raw_instr, pc, valid} to decode.
// A one-entry skid buffer absorbs decode back-pressure; a redirect squashes
// buffered entries and any request already on the bus.
module instr_fetch #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic [96:0] dataF
);

  // BOOT: idle after reset; REQ: request on the bus; WAIT: skid full, no
  // request; DROP: a squashed request is draining from the bus.
  typedef enum logic [1:0] {BOOT, REQ, WAIT, DROP} state_t;

  state_t      state, state_n;
  logic [63:0] req_addr, req_addr_n;
  logic [63:0] pend_pc, pend_pc_n;
  logic [96:0] obuf, obuf_n;
  logic [96:0] skid, skid_n;

  logic        consume;
  logic        obuf_free;
  logic [96:0] entry;

  // Sequential-PC step; wraps naturally modulo 2^64.
  function automatic logic [63:0] next_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  // Record layout: raw_instr in [96:65], pc in [64:1], valid in [0].
  assign entry     = {iresp_data, req_addr, 1'b1};
  assign consume   = obuf[0] & ~stall;
  assign obuf_free = ~obuf[0] | consume;

  assign ireq_valid = (state == REQ) || (state == DROP);
  assign ireq_addr  = req_addr;
  assign dataF      = obuf;

  // Next-state and buffer movement; a redirect overrides every valid bit.
  always_comb begin
    state_n    = state;
    req_addr_n = req_addr;
    pend_pc_n  = pend_pc;
    obuf_n     = obuf;
    skid_n     = skid;

    if (consume) obuf_n[0] = 1'b0;

    case (state)
      BOOT: begin
        state_n = REQ;
        if (redirect_valid) req_addr_n = redirect_pc;
      end
      REQ: begin
        if (redirect_valid) begin
          if (iresp_data_ok) begin
            // Response arrives with the redirect: drop it and retarget now.
            req_addr_n = redirect_pc;
          end else begin
            // Request is on the bus and must be drained before retargeting.
            pend_pc_n = redirect_pc;
            state_n   = DROP;
          end
        end else if (iresp_data_ok) begin
          req_addr_n = next_pc(req_addr);
          if (obuf_free) begin
            obuf_n = entry;
          end else begin
            skid_n  = entry;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          req_addr_n = redirect_pc;
          state_n    = REQ;
        end else if (consume) begin
          obuf_n    = skid;
          skid_n[0] = 1'b0;
          state_n   = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pend_pc_n = redirect_pc;
        if (iresp_data_ok) begin
          // A redirect in the same cycle supersedes the saved target.
          req_addr_n = redirect_valid ? redirect_pc : pend_pc;
          state_n    = REQ;
        end
      end
      default: state_n = BOOT;
    endcase

    if (redirect_valid) begin
      obuf_n[0] = 1'b0;
      skid_n[0] = 1'b0;
    end
  end

  // State and buffer registers; reset abandons any in-flight request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      req_addr <= PC_RESET;
      pend_pc  <= 64'd0;
      obuf     <= '0;
      skid     <= '0;
    end else begin
      state    <= state_n;
      req_addr <= req_addr_n;
      pend_pc  <= pend_pc_n;
      obuf     <= obuf_n;
      skid     <= skid_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a bus responder with configurable latency returning
// data = address[31:0], and an in-order delivery queue as reference model.
module tb_instr_fetch;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        stall = 1'b0;
  logic [96:0] dataF;

  always #5 clk = ~clk;

  instr_fetch #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .dataF(dataF)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Stimulus knobs set by the scenario tasks.
  logic        stall_r = 1'b0;
  logic        redir_r = 1'b0;
  logic        redir_on_ok = 1'b0;
  logic [63:0] rpc_r = 64'd0;
  int          lat = 1;

  // Bus responder and reference model.
  logic        busy = 1'b0;
  logic        doomed = 1'b0;
  int          wcnt = 0;
  logic [63:0] baddr = 64'd0;
  logic [63:0] exp_req = PC_RESET;
  logic [63:0] q[$];
  logic [63:0] acc_log[$];
  logic [63:0] cons_log[$];
  int          acc_cyc[$];
  logic        prev_hold = 1'b0;
  logic [96:0] prev_dataF = '0;

  // One clock cycle: check outputs against the model, run the bus, apply
  // stimulus, then advance the model for the coming rising edge.
  task automatic step();
    logic [63:0] popped;
    @(negedge clk);
    cyc++;
    tests++;
    if (dataF[0] !== (q.size() > 0)) begin
      fails++;
      $display("FAIL sb_valid cyc=%0d: dataF.valid=%b expected %b", cyc, dataF[0], (q.size() > 0));
    end
    if (dataF[0] === 1'b1 && q.size() > 0) begin
      tests++;
      if (dataF[64:1] !== q[0] || dataF[96:65] !== q[0][31:0]) begin
        fails++;
        $display("FAIL sb_entry cyc=%0d: pc=%h raw=%h expected pc=%h raw=%h", cyc, dataF[64:1], dataF[96:65], q[0], q[0][31:0]);
      end
    end
    if (prev_hold) begin
      tests++;
      if (dataF !== prev_dataF) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d: dataF=%h expected %h", cyc, dataF, prev_dataF);
      end
    end
    if (q.size() == 2) begin
      tests++;
      if (ireq_valid !== 1'b0) begin
        fails++;
        $display("FAIL skid_no_req cyc=%0d: ireq_valid=%b expected 0", cyc, ireq_valid);
      end
    end

    if (iresp_data_ok) begin
      iresp_data_ok = 1'b0;
      busy = 1'b0;
    end
    if (busy) begin
      tests++;
      if (ireq_valid !== 1'b1 || ireq_addr !== baddr) begin
        fails++;
        $display("FAIL req_stable cyc=%0d: valid=%b addr=%h expected 1 %h", cyc, ireq_valid, ireq_addr, baddr);
      end
      wcnt--;
      if (wcnt == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data = baddr[31:0];
      end
    end else if (ireq_valid === 1'b1) begin
      tests++;
      if (ireq_addr !== exp_req) begin
        fails++;
        $display("FAIL req_addr cyc=%0d: addr=%h expected %h", cyc, ireq_addr, exp_req);
      end
      acc_log.push_back(ireq_addr);
      acc_cyc.push_back(cyc);
      busy = 1'b1;
      baddr = ireq_addr;
      exp_req = ireq_addr + 64'd4;
      doomed = 1'b0;
      wcnt = lat;
    end

    stall = stall_r;
    redirect_pc = rpc_r;
    redirect_valid = redir_r | (redir_on_ok & iresp_data_ok);

    if (dataF[0] === 1'b1 && !stall && q.size() > 0) begin
      popped = q.pop_front();
      cons_log.push_back(popped);
    end
    if (redirect_valid) begin
      q.delete();
      exp_req = redirect_pc;
      if (busy) doomed = 1'b1;
    end else if (iresp_data_ok && !doomed) begin
      q.push_back(baddr);
    end
    prev_hold = dataF[0] && stall && !redirect_valid;
    prev_dataF = dataF;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    iresp_data_ok = 1'b0; iresp_data = 32'd0;
    stall_r = 1'b0; redir_r = 1'b0; redir_on_ok = 1'b0; lat = 1;
    busy = 1'b0; doomed = 1'b0; exp_req = PC_RESET; prev_hold = 1'b0;
    q.delete(); acc_log.delete(); acc_cyc.delete(); cons_log.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (ireq_valid !== 1'b0 || ireq_addr !== PC_RESET || dataF !== '0) begin
      fails++;
      $display("FAIL reset_values: valid=%b addr=%h dataF=%h expected 0 %h 0", ireq_valid, ireq_addr, dataF, PC_RESET);
    end
    apply_reset();
    tests++;
    if (ireq_valid !== 1'b0) begin
      fails++;
      $display("FAIL boot_no_req: ireq_valid=%b expected 0", ireq_valid);
    end
  endtask

  task automatic test_boot();
    apply_reset();
    repeat (10) step();
    tests++;
    if (acc_log.size() < 3) begin
      fails++;
      $display("FAIL boot_req_count: %0d requests expected >=3", acc_log.size());
    end else if (acc_log[0] !== 64'h8000_0000 || acc_log[1] !== 64'h8000_0004 || acc_log[2] !== 64'h8000_0008) begin
      fails++;
      $display("FAIL boot_req_seq: %h %h %h expected 80000000 80000004 80000008", acc_log[0], acc_log[1], acc_log[2]);
    end
    tests++;
    if (acc_cyc.size() < 2 || (acc_cyc[1] - acc_cyc[0]) != 2) begin
      fails++;
      $display("FAIL boot_throughput: request spacing wrong, %0d requests", acc_cyc.size());
    end
    tests++;
    if (cons_log.size() < 3 || cons_log[0] !== 64'h8000_0000 || cons_log[2] !== 64'h8000_0008) begin
      fails++;
      $display("FAIL boot_delivery: %0d delivered expected >=3 starting at 80000000", cons_log.size());
    end
  endtask

  task automatic test_stall_skid();
    int n;
    apply_reset();
    stall_r = 1'b1;
    n = 0;
    do begin step(); n++; end while (dataF[0] !== 1'b1 && n < 20);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (dataF[0] !== 1'b1 || dataF[64:1] !== 64'h8000_0000) begin
        fails++;
        $display("FAIL stall_obuf: valid=%b pc=%h expected 1 80000000", dataF[0], dataF[64:1]);
      end
      step();
    end
    tests++;
    if (ireq_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_wait_req: ireq_valid=%b expected 0", ireq_valid);
    end
    stall_r = 1'b0;
    repeat (10) step();
    tests++;
    if (cons_log.size() < 3 || cons_log[0] !== 64'h8000_0000 || cons_log[1] !== 64'h8000_0004 || cons_log[2] !== 64'h8000_0008) begin
      fails++;
      $display("FAIL stall_order: %0d delivered, expected 80000000,4,8 in order", cons_log.size());
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    apply_reset();
    lat = 3;
    n = 0;
    do begin step(); n++; end while (!busy && n < 20);
    redir_r = 1'b1; rpc_r = 64'h8000_0100;
    step();
    redir_r = 1'b0;
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
      fails++;
      $display("FAIL drop_hold_addr: valid=%b addr=%h expected 1 80000000", ireq_valid, ireq_addr);
    end
    repeat (14) step();
    tests++;
    if (acc_log.size() < 2 || acc_log[1] !== 64'h8000_0100) begin
      fails++;
      $display("FAIL drop_next_req: %0d requests, expected second at 80000100", acc_log.size());
    end
    tests++;
    if (cons_log.size() < 1 || cons_log[0] !== 64'h8000_0100) begin
      fails++;
      $display("FAIL drop_squash: %0d delivered, expected first pc 80000100", cons_log.size());
    end
  endtask

  task automatic test_redirect_coincident();
    int n;
    apply_reset();
    redir_on_ok = 1'b1; rpc_r = 64'h8000_0040;
    n = 0;
    do begin step(); n++; end while (redirect_valid !== 1'b1 && n < 20);
    redir_on_ok = 1'b0;
    step();
    tests++;
    if (dataF[0] !== 1'b0) begin
      fails++;
      $display("FAIL coinc_valid: dataF.valid=%b expected 0", dataF[0]);
    end
    tests++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0040) begin
      fails++;
      $display("FAIL coinc_next_req: valid=%b addr=%h expected 1 80000040", ireq_valid, ireq_addr);
    end
    repeat (6) step();
    tests++;
    if (cons_log.size() < 1 || cons_log[0] !== 64'h8000_0040) begin
      fails++;
      $display("FAIL coinc_first: %0d delivered, expected first pc 80000040", cons_log.size());
    end
  endtask

  task automatic test_redirect_stall();
    int n;
    apply_reset();
    stall_r = 1'b1;
    n = 0;
    do begin step(); n++; end while (q.size() != 2 && n < 20);
    tests++;
    if (q.size() != 2) begin
      fails++;
      $display("FAIL rs_fill: buffers did not fill, %0d entries", q.size());
    end
    redir_r = 1'b1; rpc_r = 64'h8000_0200;
    step();
    redir_r = 1'b0;
    step();
    tests++;
    if (dataF[0] !== 1'b0) begin
      fails++;
      $display("FAIL rs_flush: dataF.valid=%b expected 0", dataF[0]);
    end
    n = 0;
    do begin step(); n++; end while (dataF[0] !== 1'b1 && n < 20);
    tests++;
    if (dataF[0] !== 1'b1 || dataF[64:1] !== 64'h8000_0200) begin
      fails++;
      $display("FAIL rs_first: valid=%b pc=%h expected 1 80000200", dataF[0], dataF[64:1]);
    end
    stall_r = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_wrap_async_reset();
    int n;
    apply_reset();
    repeat (3) step();
    redir_r = 1'b1; rpc_r = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redir_r = 1'b0;
    acc_log.delete(); cons_log.delete();
    repeat (10) step();
    tests++;
    if (acc_log.size() < 2 || acc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || acc_log[1] !== 64'd0) begin
      fails++;
      $display("FAIL wrap_req: %0d requests, expected FFFFFFFFFFFFFFFC then 0", acc_log.size());
    end
    tests++;
    if (cons_log.size() < 2 || cons_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || cons_log[1] !== 64'd0) begin
      fails++;
      $display("FAIL wrap_deliver: %0d delivered, expected FFFFFFFFFFFFFFFC then 0", cons_log.size());
    end
    n = 0;
    do begin step(); n++; end while (!(dataF[0] === 1'b1 && ireq_valid === 1'b1) && n < 20);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (ireq_valid !== 1'b0 || dataF[0] !== 1'b0 || ireq_addr !== PC_RESET) begin
      fails++;
      $display("FAIL async_reset: valid=%b dataF.valid=%b addr=%h expected 0 0 %h", ireq_valid, dataF[0], ireq_addr, PC_RESET);
    end
    apply_reset();
    repeat (6) step();
    tests++;
    if (acc_log.size() < 1 || acc_log[0] !== PC_RESET) begin
      fails++;
      $display("FAIL restart: %0d requests, expected first at %h", acc_log.size(), PC_RESET);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      stall_r = ($urandom_range(0, 99) < 30);
      lat = $urandom_range(1, 3);
      redir_r = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0)
        rpc_r = 64'hFFFF_FFFF_FFFF_FFF0 | (64'($urandom_range(0, 3)) << 2);
      else
        rpc_r = {$urandom(), $urandom()} & ~64'h3;
      step();
    end
    redir_r = 1'b0; stall_r = 1'b0;
    repeat (10) step();
    tests++;
    if (cons_log.size() < 50) begin
      fails++;
      $display("FAIL random_progress: %0d delivered expected >=50", cons_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_stall();
    test_wrap_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
